// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns
// (active-low, a..g on bits 6..0), converter state encoding, BCD sizing.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SHIFT,
      ST_COMMIT
   } conv_state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   // Decimal digits needed for any NUM_W-bit value: smallest d with 10^d >= 2^n.
   function automatic int bcd_digits(input int num_w);
      longint unsigned lim;
      longint unsigned p;
      int d;
      lim = 64'd1 << num_w;
      p   = 64'd1;
      d   = 0;
      for (int i = 0; i < 20; i++) begin
         if (p < lim) begin
            p = p * 64'd10;
            d++;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, free-running LOAD/SHIFT/COMMIT.
// Ports: clk, rst (sync active-low), bin in, bcd committed result, valid 1-cycle pulse.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int NUM_W = 13
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_W-1:0]                  bin,
   output logic [4*bcd_digits(NUM_W)-1:0]    bcd,
   output logic                              valid
);

   localparam int BCD_N = bcd_digits(NUM_W);
   localparam int BW    = 4 * BCD_N;
   localparam int CW    = $clog2(NUM_W + 1);

   conv_state_t     state;
   logic [NUM_W-1:0] sr;
   logic [BW-1:0]   acc;
   logic [BW-1:0]   adj;
   logic [CW-1:0]   cnt;

   // Add-3 correction of every nibble >= 5 ahead of the shift.
   always_comb begin
      adj = acc;
      for (int i = 0; i < BCD_N; i++) begin
         if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_LOAD;
         sr    <= '0;
         acc   <= '0;
         cnt   <= '0;
         bcd   <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         unique case (state)
            ST_LOAD: begin
               sr    <= bin;
               acc   <= '0;
               cnt   <= '0;
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               {acc, sr} <= {adj, sr} << 1;
               cnt       <= cnt + 1'b1;
               if (cnt == CW'(NUM_W - 1)) state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               // Whole result lands in one edge; display never sees a mix.
               bcd   <= acc;
               valid <= 1'b1;
               state <= ST_LOAD;
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed seven-segment driver: decimal conversion, digit scan, blanking, decode.
// Ports: clk, rst (sync active-low), en, num, blank_lz, dp -> anode, led_out, dp_out, bcd_valid.
module seven_segment_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int NUM_W        = 13,
   parameter int REFRESH_BITS = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_W-1:0]  num,
   input  logic              blank_lz,
   input  logic [DIGITS-1:0] dp,
   output logic [DIGITS-1:0] anode,
   output logic [6:0]        led_out,
   output logic              dp_out,
   output logic              bcd_valid
);

   localparam int BCD_N = bcd_digits(NUM_W);
   localparam int PAD_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
   localparam int PW    = 4 * PAD_N;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*BCD_N-1:0]      bcd;
   logic [PW-1:0]           digs;
   logic                    ovf;
   logic                    all_zero;
   logic [DIGITS-1:0]       lz;
   logic [IDX_W-1:0]        pos;
   logic [3:0]              cur;
   logic                    cur_lz;
   logic                    cur_dp;
   logic [DIGITS-1:0]       anode_n;
   logic [6:0]              seg_n;
   logic [REFRESH_BITS-1:0] dwell;
   logic [IDX_W-1:0]        idx;

   bin2bcd_seq #(
      .NUM_W(NUM_W)
   ) u_conv (
      .clk   (clk),
      .rst   (rst),
      .bin   (num),
      .bcd   (bcd),
      .valid (bcd_valid)
   );

   // Digit j holds the 10^j place; padded so every display position exists.
   assign digs = PW'(bcd);

   // Any nonzero place beyond the display means the value does not fit.
   always_comb begin
      ovf = 1'b0;
      for (int i = DIGITS; i < PAD_N; i++) begin
         if (digs[4*i +: 4] != 4'd0) ovf = 1'b1;
      end
   end

   // A place is a leading zero when it and everything above it is zero.
   always_comb begin
      lz       = '0;
      all_zero = 1'b1;
      for (int j = DIGITS - 1; j >= 1; j--) begin
         all_zero = all_zero & (digs[4*j +: 4] == 4'd0);
         lz[j]    = blank_lz & all_zero;
      end
   end

   // Scan index 0 is the leftmost digit, i.e. place DIGITS-1.
   always_comb begin
      pos     = IDX_W'(DIGITS - 1) - idx;
      cur     = 4'd0;
      cur_lz  = 1'b0;
      cur_dp  = 1'b0;
      anode_n = '1;
      for (int j = 0; j < DIGITS; j++) begin
         if (pos == IDX_W'(j)) begin
            cur        = digs[4*j +: 4];
            cur_lz     = lz[j];
            cur_dp     = dp[j];
            anode_n[j] = 1'b0;
         end
      end
      if (ovf)              seg_n = SEG_DASH;
      else if (cur_lz)      seg_n = SEG_BLANK;
      else if (cur > 4'd9)  seg_n = SEG_DASH;
      else                  seg_n = SEG_DIGIT[cur];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dwell   <= '0;
         idx     <= '0;
         anode   <= '1;
         led_out <= SEG_BLANK;
         dp_out  <= 1'b1;
      end else if (en) begin
         anode   <= anode_n;
         led_out <= seg_n;
         dp_out  <= ~cur_dp;
         dwell   <= dwell + 1'b1;
         if (&dwell) begin
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end
      end else begin
         anode   <= '1;
         led_out <= SEG_BLANK;
         dp_out  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: 4-digit and 3-digit instances,
// table vectors, hand sequences and a cycle-level reference model.
module tb_seven_segment_scan_driver;

   localparam int NW  = 13;
   localparam int RB  = 2;
   localparam int PER = NW + 2;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b0100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] DS = 7'b1111110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, en, blank_lz;
   logic [NW-1:0] num_a, num_b;
   logic [3:0]    dp_a, anode_a;
   logic [2:0]    dp_b, anode_b;
   logic [6:0]    led_a, led_b;
   logic          dpo_a, dpo_b, val_a, val_b;

   seven_segment_scan_driver #(
      .DIGITS(4), .NUM_W(NW), .REFRESH_BITS(RB)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .num(num_a), .blank_lz(blank_lz),
      .dp(dp_a), .anode(anode_a), .led_out(led_a), .dp_out(dpo_a),
      .bcd_valid(val_a)
   );

   seven_segment_scan_driver #(
      .DIGITS(3), .NUM_W(NW), .REFRESH_BITS(RB)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .num(num_b), .blank_lz(blank_lz),
      .dp(dp_b), .anode(anode_b), .led_out(led_b), .dp_out(dpo_b),
      .bcd_valid(val_b)
   );

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         t;
      int         sampled;
      int         shown;
      int         dwell;
      int         idx;
      logic [7:0] anode;
      logic [6:0] led;
      logic       dpo;
      logic       valid;
   } mdl_t;

   function automatic int p10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] seg7(input int v);
      case (v)
         0: return S0;
         1: return S1;
         2: return S2;
         3: return 7'b0000110;
         4: return S4;
         5: return S5;
         6: return S6;
         7: return S7;
         8: return S8;
         9: return S9;
         default: return DS;
      endcase
   endfunction

   // Pattern for decimal place j of value v on a d-digit display.
   function automatic logic [6:0] exp_seg(input int v, input int j,
                                          input int d, input logic bl);
      if (v >= p10(d)) return DS;
      if (bl && j > 0 && v < p10(j)) return BL;
      return seg7((v / p10(j)) % 10);
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input int d, input logic r,
                                  input logic e, input int n, input logic bl,
                                  input logic [7:0] dpv);
      mdl_t o;
      int   j;
      o = m;
      if (!r) begin
         o.t = 0; o.sampled = 0; o.shown = 0; o.dwell = 0; o.idx = 0;
         o.anode = '1; o.led = BL; o.dpo = 1'b1; o.valid = 1'b0;
         return o;
      end
      j = d - 1 - m.idx;
      o.anode = '1;
      o.led   = BL;
      o.dpo   = 1'b1;
      if (e) begin
         o.anode[j] = 1'b0;
         o.led      = exp_seg(m.shown, j, d, bl);
         o.dpo      = ~dpv[j];
      end
      o.valid = 1'b0;
      if (m.t % PER == 0) o.sampled = n;
      if (m.t % PER == PER - 1) begin
         o.shown = m.sampled;
         o.valid = 1'b1;
      end
      o.t = m.t + 1;
      if (e) begin
         if (m.dwell == (1 << RB) - 1) o.idx = (m.idx + 1) % d;
         o.dwell = (m.dwell + 1) % (1 << RB);
      end
      return o;
   endfunction

   mdl_t ma, mb;

   always @(posedge clk) begin
      ma <= mstep(ma, 4, rst, en, int'(num_a), blank_lz, {4'b0, dp_a});
      mb <= mstep(mb, 3, rst, en, int'(num_b), blank_lz, {5'b0, dp_b});
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_anode_a", anode_a, ma.anode[3:0]);
         chk("m_led_a",   led_a,   ma.led);
         chk("m_dp_a",    dpo_a,   ma.dpo);
         chk("m_valid_a", val_a,   ma.valid);
         chk("m_anode_b", anode_b, mb.anode[2:0]);
         chk("m_led_b",   led_b,   mb.led);
         chk("m_dp_b",    dpo_b,   mb.dpo);
         chk("m_valid_b", val_b,   mb.valid);
      end
   end

   // ---------------- helpers ----------------
   logic [6:0] ga [4];
   logic [6:0] gb [3];

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (val_a !== 1'b1 && n < 40);
      chk("valid_timeout", (n < 40), 1);
   endtask

   // First led pattern seen on each scan position over 15 cycles.
   task automatic scan();
      bit sa [4];
      bit sb [3];
      for (int k = 0; k < 4; k++) begin ga[k] = 'x; sa[k] = 0; end
      for (int k = 0; k < 3; k++) begin gb[k] = 'x; sb[k] = 0; end
      repeat (15) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (!sa[k] && anode_a == ~(4'b1000 >> k)) begin
               ga[k] = led_a; sa[k] = 1;
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (!sb[k] && anode_b == ~(3'b100 >> k)) begin
               gb[k] = led_b; sb[k] = 1;
            end
         end
      end
   endtask

   task automatic first_valid(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (val_a !== 1'b1 && n < 40);
      chk(nm, n, PER);
   endtask

   typedef struct {
      int          na;
      logic        bl;
      logic [27:0] ea;
      int          nb;
      logic [20:0] eb;
   } vec_t;

   vec_t tv [8];

   initial begin
      tv[0] = '{na:1234, bl:1'b0, ea:{S1, S2, 7'b0000110, S4},
                nb:1000, eb:{DS, DS, DS}};
      tv[1] = '{na:42,   bl:1'b1, ea:{BL, BL, S4, S2},
                nb:7,    eb:{BL, BL, S7}};
      tv[2] = '{na:42,   bl:1'b0, ea:{S0, S0, S4, S2},
                nb:999,  eb:{S9, S9, S9}};
      tv[3] = '{na:8191, bl:1'b0, ea:{S8, S1, S9, S1},
                nb:8191, eb:{DS, DS, DS}};
      tv[4] = '{na:0,    bl:1'b0, ea:{S0, S0, S0, S0},
                nb:0,    eb:{S0, S0, S0}};
      tv[5] = '{na:0,    bl:1'b1, ea:{BL, BL, BL, S0},
                nb:0,    eb:{BL, BL, S0}};
      tv[6] = '{na:5067, bl:1'b1, ea:{S5, S0, S6, S7},
                nb:50,   eb:{BL, S5, S0}};
      tv[7] = '{na:100,  bl:1'b1, ea:{BL, S1, S0, S0},
                nb:205,  eb:{S2, S0, S5}};

      rst = 1'b0; en = 1'b1; blank_lz = 1'b0;
      num_a = 13'd1234; num_b = 13'd1000; dp_a = '0; dp_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_anode", anode_a, 4'hF);
      chk("rst_led",   led_a,   BL);
      chk("rst_dp",    dpo_a,   1'b1);
      chk("rst_valid", val_a,   1'b0);
      chk_on = 1'b1;
      rst = 1'b1;
      first_valid("first_valid_cycle");

      for (int i = 0; i < 8; i++) begin
         num_a = NW'(tv[i].na);
         num_b = NW'(tv[i].nb);
         blank_lz = tv[i].bl;
         wait_valid();
         wait_valid();
         @(negedge clk);
         scan();
         for (int k = 0; k < 4; k++)
            chk($sformatf("tab%0d_a_d%0d", i, k), ga[k], tv[i].ea[27-7*k -: 7]);
         for (int k = 0; k < 3; k++)
            chk($sformatf("tab%0d_b_d%0d", i, k), gb[k], tv[i].eb[20-7*k -: 7]);
      end

      // Value changed mid-SHIFT: old sample commits first, then the new one.
      blank_lz = 1'b0;
      num_a = 13'd1111;
      wait_valid();
      wait_valid();
      repeat (3) @(negedge clk);
      num_a = 13'd2222;
      wait_valid();
      @(negedge clk);
      scan();
      for (int k = 0; k < 4; k++) chk($sformatf("midshift_old_d%0d", k), ga[k], S1);
      wait_valid();
      @(negedge clk);
      scan();
      for (int k = 0; k < 4; k++) chk($sformatf("midshift_new_d%0d", k), ga[k], S2);

      // Decimal point follows the selected digit.
      dp_a = 4'b0100;
      repeat (16) begin
         @(negedge clk);
         chk("dp_vs_anode", dpo_a, (anode_a == 4'b1011) ? 1'b0 : 1'b1);
      end

      en = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("en0_anode", anode_a, 4'hF);
         chk("en0_led",   led_a,   BL);
         chk("en0_dp",    dpo_a,   1'b1);
      end
      en = 1'b1;

      // Reset in the middle of SHIFT.
      wait_valid();
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst2_anode", anode_a, 4'hF);
      chk("rst2_led",   led_a,   BL);
      chk("rst2_dp",    dpo_a,   1'b1);
      chk("rst2_valid", val_a,   1'b0);
      rst = 1'b1;
      first_valid("first_valid_after_rst");
      dp_a = '0;

      // Randomized traffic against the model.
      repeat (2500) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) num_a = NW'($urandom_range(0, 8191));
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) num_b = NW'($urandom_range(0, 8191));
            else num_b = NW'($urandom_range(990, 1010));
         end
         if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 9) == 0) begin
            dp_a = 4'($urandom);
            dp_b = 3'($urandom);
         end
         if ($urandom_range(0, 15) == 0) en = ~en;
         rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
